// File: rtl/l_next_mem.sv
// l_next_mem: cycle-accurate next-level memory model behind the L1 caches.
// Accepts one line request at a time from NCH requester channels (round-robin),
// waits LATENCY cycles, then returns the address-derived line pattern (read) or
// an all-zero write acknowledge (writeback) to the granted channel.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-channel request valid
//   req_we       per-channel request type (1 = writeback, 0 = line read)
//   req_add_in   per-channel line address, channel c at [c*ADDR_W +: ADDR_W]
//   req_ready    per-channel accept, combinational, at most one bit high
//   rsp_valid    one-cycle response pulse to the serviced channel
//   rsp_we       echo of the serviced request type
//   rsp_data_out line data, word 0 in the MSBs
//   busy         high while a request is in flight (BUSY and RESP)
module l_next_mem #(
   parameter int unsigned ADDR_W  = 26,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned WORDS   = 16,
   parameter int unsigned LATENCY = 4,
   parameter int unsigned NCH     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NCH-1:0]            req_valid,
   input  logic [NCH-1:0]            req_we,
   input  logic [NCH*ADDR_W-1:0]     req_add_in,
   output logic [NCH-1:0]            req_ready,
   output logic [NCH-1:0]            rsp_valid,
   output logic                      rsp_we,
   output logic [WORDS*WORD_W-1:0]   rsp_data_out,
   output logic                      busy
);

   localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned IW = WORD_W - ADDR_W;
   localparam int unsigned LW = WORDS * WORD_W;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   state_t            state;
   logic [PW-1:0]     rr_ptr;    // last granted channel; also the channel in service
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;

   logic [PW-1:0]     grant;
   logic              grant_vld;
   logic [PW-1:0]     idx;
   logic [ADDR_W-1:0] addr_g;

   function automatic logic [LW-1:0] line_pattern(input logic [ADDR_W-1:0] a);
      logic [LW-1:0] l;
      l = '0;
      for (int unsigned k = 0; k < WORDS; k++) begin
         l[(WORDS-1-k)*WORD_W +: WORD_W] = {a, IW'(k)};
      end
      return l;
   endfunction

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         idx = PW'((32'(rr_ptr) + i) % NCH);
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   assign addr_g    = req_add_in[grant*ADDR_W +: ADDR_W];
   assign req_ready = (state == StIdle && grant_vld) ? (NCH'(1) << grant) : '0;
   assign busy      = (state != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         rr_ptr       <= PW'(NCH-1);
         cnt          <= '0;
         lat_addr     <= '0;
         lat_we       <= 1'b0;
         rsp_valid    <= '0;
         rsp_we       <= 1'b0;
         rsp_data_out <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (grant_vld) begin
                  rr_ptr   <= grant;
                  lat_addr <= addr_g;
                  lat_we   <= req_we[grant];
                  cnt      <= CW'(LATENCY-1);
                  if (LATENCY == 1) begin
                     // No BUSY phase: the response is built straight from the request.
                     state        <= StResp;
                     rsp_valid    <= NCH'(1) << grant;
                     rsp_we       <= req_we[grant];
                     rsp_data_out <= req_we[grant] ? '0 : line_pattern(addr_g);
                  end else begin
                     state <= StBusy;
                  end
               end
            end
            StBusy: begin
               if (cnt <= CW'(1)) begin
                  state        <= StResp;
                  rsp_valid    <= NCH'(1) << rr_ptr;
                  rsp_we       <= lat_we;
                  rsp_data_out <= lat_we ? '0 : line_pattern(lat_addr);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            StResp: begin
               state        <= StIdle;
               rsp_valid    <= '0;
               rsp_we       <= 1'b0;
               rsp_data_out <= '0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_l_next_mem.sv
// Self-checking bench for l_next_mem: directed cases plus randomized traffic on a
// default build (NCH=2, LATENCY=4), and a rotation check on an NCH=4, LATENCY=1 build.
// The reference model works on transactions and cycle numbers: a request accepted
// in cycle c answers in cycle c+LAT and the block is free again at c+LAT+1.
module tb_l_next_mem;

   localparam int AW    = 26;
   localparam int WW    = 32;
   localparam int WD    = 16;
   localparam int LAT   = 4;
   localparam int NC    = 2;
   localparam int QN    = 4;
   localparam int DW    = WW * WD;
   localparam int SCALE = 1 << (WW - AW);

   logic            clk;
   logic            rst_n;

   logic [NC-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [NC*AW-1:0] req_add_in;
   logic             rsp_we, busy;
   logic [DW-1:0]    rsp_data_out;

   logic [QN-1:0]    q_valid, q_we, q_ready, q_rsp_valid;
   logic [QN*AW-1:0] q_add_in;
   logic             q_rsp_we, q_busy;
   logic [DW-1:0]    q_data;

   l_next_mem #(.ADDR_W(AW), .WORD_W(WW), .WORDS(WD), .LATENCY(LAT), .NCH(NC)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_add_in(req_add_in), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_we(rsp_we), .rsp_data_out(rsp_data_out), .busy(busy)
   );

   l_next_mem #(.ADDR_W(AW), .WORD_W(WW), .WORDS(WD), .LATENCY(1), .NCH(QN)) u_q (
      .clk(clk), .rst_n(rst_n), .req_valid(q_valid), .req_we(q_we),
      .req_add_in(q_add_in), .req_ready(q_ready), .rsp_valid(q_rsp_valid),
      .rsp_we(q_rsp_we), .rsp_data_out(q_data), .busy(q_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Word k of a read line is addr * 2^(WW-AW) + k, word 0 at the top.
   function automatic logic [DW-1:0] model_line(input logic [AW-1:0] a);
      logic [DW-1:0] l;
      l = '0;
      for (int k = 0; k < WD; k++) l[(WD-1-k)*WW +: WW] = WW'(a) * WW'(SCALE) + WW'(k);
      return l;
   endfunction

   // Model and driver state
   int            cyc;
   bit            have_rsp;
   int            rsp_cyc, rsp_ch, last;
   bit            m_we;
   logic [AW-1:0] m_addr;
   bit            accepted[NC], outstanding[NC];
   bit            pend_v[NC], pend_we[NC];
   logic [AW-1:0] pend_addr[NC];
   int            rate;

   // Observations, used only for directed timing checks
   int            obs_gnt[$], obs_acc[$], obs_rch[$], obs_rcyc[$];
   logic [DW-1:0] last_data;
   logic          last_we;

   task automatic model_reset();
      have_rsp = 0;
      last     = NC - 1;
      for (int c = 0; c < NC; c++) begin
         accepted[c] = 0; outstanding[c] = 0; pend_v[c] = 0;
      end
      req_valid = '0;
      req_we    = '0;
   endtask

   task automatic clear_obs();
      obs_gnt.delete(); obs_acc.delete(); obs_rch.delete(); obs_rcyc.delete();
   endtask

   task automatic issue(input int ch, input bit we, input logic [AW-1:0] a);
      pend_v[ch] = 1; pend_we[ch] = we; pend_addr[ch] = a;
   endtask

   task automatic drive();
      cyc++;
      for (int c = 0; c < NC; c++) begin
         if (accepted[c]) begin
            req_valid[c]   = 1'b0;
            accepted[c]    = 0;
            outstanding[c] = 1;
         end else if (!req_valid[c] && !outstanding[c]) begin
            if (pend_v[c]) begin
               req_valid[c] = 1'b1;
               req_we[c]    = pend_we[c];
               req_add_in[c*AW +: AW] = pend_addr[c];
               pend_v[c]    = 0;
            end else if (rate != 0 && $urandom_range(rate - 1) == 0) begin
               req_valid[c] = 1'b1;
               req_we[c]    = 1'($urandom_range(1));
               case ($urandom_range(3))
                  0:       req_add_in[c*AW +: AW] = '0;
                  1:       req_add_in[c*AW +: AW] = '1;
                  default: req_add_in[c*AW +: AW] = AW'($urandom);
               endcase
            end
         end
      end
   endtask

   task automatic sample();
      bit            idle, found;
      logic [NC-1:0] exp_rv, exp_rdy;
      int            ch;
      idle = !have_rsp;
      check("busy", 512'(busy), 512'(have_rsp));
      exp_rv = '0;
      if (have_rsp && cyc == rsp_cyc) exp_rv[rsp_ch] = 1'b1;
      check("rsp_valid", 512'(rsp_valid), 512'(exp_rv));
      if (exp_rv != '0) begin
         check("rsp_we", 512'(rsp_we), 512'(m_we));
         check("rsp_data", rsp_data_out, m_we ? '0 : model_line(m_addr));
         have_rsp = 0;
         outstanding[rsp_ch] = 0;
      end else begin
         check("rsp_data_idle", rsp_data_out, '0);
      end
      for (int c = 0; c < NC; c++) begin
         if (rsp_valid[c]) begin
            obs_rch.push_back(c); obs_rcyc.push_back(cyc);
            last_data = rsp_data_out; last_we = rsp_we;
         end
         if (req_ready[c]) begin
            obs_gnt.push_back(c); obs_acc.push_back(cyc);
         end
      end
      exp_rdy = '0;
      found   = 0;
      if (idle) begin
         for (int i = 1; i <= NC; i++) begin
            ch = (last + i) % NC;
            if (!found && req_valid[ch]) begin
               found = 1;
               exp_rdy[ch] = 1'b1;
               have_rsp = 1;
               rsp_cyc  = cyc + LAT;
               rsp_ch   = ch;
               m_we     = req_we[ch];
               m_addr   = req_add_in[ch*AW +: AW];
               accepted[ch] = 1;
               last     = ch;
            end
         end
      end
      check("req_ready", 512'(req_ready), 512'(exp_rdy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      sample();
   endtask

   initial begin
      rst_n      = 1'b0;
      req_add_in = '0;
      q_valid    = '0;
      q_we       = '0;
      q_add_in   = '0;
      cyc        = 0;
      rate       = 0;
      last_data  = '0;
      last_we    = 1'b0;
      model_reset();
      clear_obs();

      // Reset values
      #12;
      check("rst_ready", 512'(req_ready), '0);
      check("rst_rsp_valid", 512'(rsp_valid), '0);
      check("rst_rsp_we", 512'(rsp_we), '0);
      check("rst_data", rsp_data_out, '0);
      check("rst_busy", 512'(busy), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single read on ch1, latency 4
      issue(1, 0, 26'h0ABCDEF);
      repeat (8) step();
      check("t1_nrsp", 512'(obs_rcyc.size()), 512'(1));
      check("t1_ch", 512'(obs_rch[0]), 512'(1));
      check("t1_lat", 512'(obs_rcyc[0] - obs_acc[0]), 512'(4));
      check("t1_w0", 512'(last_data[511:480]), 512'(32'h2AF37BC0));
      check("t1_w15", 512'(last_data[31:0]), 512'(32'h2AF37BCF));
      check("t1_we", 512'(last_we), '0);

      // Simultaneous reads on both channels
      clear_obs();
      issue(0, 0, 26'h1234567);
      issue(1, 0, 26'h2000001);
      repeat (16) step();
      check("t2_g0", 512'(obs_gnt[0]), 512'(0));
      check("t2_g1", 512'(obs_gnt[1]), 512'(1));
      check("t2_r0", 512'(obs_rch[0]), 512'(0));
      check("t2_r1", 512'(obs_rch[1]), 512'(1));
      check("t2_space", 512'(obs_rcyc[1] - obs_rcyc[0]), 512'(5));
      check("t2_regrant", 512'(obs_acc[1] - obs_rcyc[0]), 512'(1));

      // Writeback on ch0, all-ones address
      clear_obs();
      issue(0, 1, 26'h3FFFFFF);
      repeat (8) step();
      check("t3_ch", 512'(obs_rch[0]), 512'(0));
      check("t3_we", 512'(last_we), 512'(1));
      check("t3_data", last_data, '0);

      // Reset while a request is in BUSY
      clear_obs();
      issue(0, 0, 26'h0000155);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      check("t4_busy", 512'(busy), '0);
      check("t4_rsp_valid", 512'(rsp_valid), '0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_obs();
      repeat (8) step();
      check("t4_no_rsp", 512'(obs_rcyc.size()), '0);
      issue(1, 0, 26'h0000AAA);
      issue(0, 0, 26'h0000555);
      repeat (12) step();
      check("t4_prio", 512'(obs_gnt[0]), 512'(0));
      check("t4_nrsp", 512'(obs_rcyc.size()), 512'(2));

      // Randomized traffic, then drain
      rate = 3;
      repeat (600) step();
      rate = 0;
      repeat (12) step();

      // NCH=4, LATENCY=1: all channels requesting continuously
      rst_n = 1'b0;
      req_valid = '0;
      for (int c = 0; c < QN; c++) q_add_in[c*AW +: AW] = AW'(c);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      q_valid = '1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("q_ready", 512'(q_ready), (i % 2 == 0) ? 512'(1 << ((i / 2) % QN)) : '0);
         check("q_rsp_valid", 512'(q_rsp_valid),
               (i % 2 == 1) ? 512'(1 << (((i - 1) / 2) % QN)) : '0);
         check("q_busy", 512'(q_busy), 512'(i % 2));
         if (i % 2 == 1) check("q_data", q_data, model_line(AW'(((i - 1) / 2) % QN)));
         @(posedge clk);
         #1;
      end
      q_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
